// File: rtl/param_fifo.sv
// Single-clock FIFO with registered occupancy, watermark flags and overflow/underflow pulses.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read port.
module param_fifo #(
    parameter int DWIDTH        = 32,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4,
    localparam int ADDR_W       = $clog2(DEPTH)
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    output logic [DWIDTH-1:0] pop_data,
    output logic              pop_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] AFULL_L  = (ADDR_W+1)'(AFULL_THRESH);
    localparam logic [ADDR_W:0] AEMPTY_L = (ADDR_W+1)'(AEMPTY_THRESH);

    logic [DWIDTH-1:0] mem [DEPTH];

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] level_q, level_d;
    logic            empty_q, empty_d;
    logic            full_q, full_d;
    logic            aempty_q, aempty_d;
    logic            afull_q, afull_d;
    logic            overflow_q, underflow_q;
    logic            push_acc, pop_acc;

    // Acceptance looks only at the registered flags, so a pop cannot make room for a push in the same cycle.
    assign push_acc = push & ~full_q;
    assign pop_acc  = pop & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_acc)  rd_ptr_d = rd_ptr_q + 1'b1;
        level_d  = wr_ptr_d - rd_ptr_d;
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
                   (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
        aempty_d = (level_d <= AEMPTY_L);
        afull_d  = (level_d >= AFULL_L);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            aempty_q    <= 1'b1;
            afull_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            aempty_q    <= aempty_d;
            afull_q     <= afull_d;
            overflow_q  <= push & full_q;
            underflow_q <= pop & empty_q;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge aclk) begin
        if (push_acc) mem[wr_ptr_q[ADDR_W-1:0]] <= push_data;
    end

`ifdef FIFO_FWFT_EN
    assign pop_data  = empty_q ? '0 : mem[rd_ptr_q[ADDR_W-1:0]];
    assign pop_valid = ~empty_q;
`else
    logic [DWIDTH-1:0] pop_data_q;
    logic              pop_valid_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
        end else begin
            pop_valid_q <= pop_acc;
            if (pop_acc) pop_data_q <= mem[rd_ptr_q[ADDR_W-1:0]];
        end
    end

    assign pop_data  = pop_data_q;
    assign pop_valid = pop_valid_q;
`endif

    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = aempty_q;
    assign almost_full  = afull_q;
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard bench for param_fifo: stimulus queues expected words, a negedge monitor retires them.
module tb_param_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          push = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic          pop = 1'b0;
    logic [DW-1:0] pop_data;
    logic          pop_valid, empty, full, almost_empty, almost_full, overflow, underflow;
    logic [4:0]    level;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] sb_q[$];
    int mlevel = 0;

    param_fifo #(.DWIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(12), .AEMPTY_THRESH(4)) dut (
        .aclk(aclk), .areset(areset), .push(push), .push_data(push_data), .pop(pop),
        .pop_data(pop_data), .pop_valid(pop_valid), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full), .level(level),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: retires the oldest expected word whenever the DUT hands one over.
    always @(negedge aclk) begin
        if (!areset) begin
`ifdef FIFO_FWFT_EN
            if (pop_valid && pop) begin
`else
            if (pop_valid) begin
`endif
                if (sb_q.size() == 0) begin
                    chk("unexpected_pop_valid", 32'(pop_valid), 32'd0);
                end else begin
                    chk("pop_data", pop_data, sb_q.pop_front());
                end
            end
        end
    end

    // One clock of stimulus; the model decides acceptance from pre-edge occupancy.
    task automatic step(input logic p, input logic [DW-1:0] d, input logic r);
        bit pa, ra;
        push = p; push_data = d; pop = r;
        pa = p && (mlevel < DEPTH);
        ra = r && (mlevel > 0);
        if (pa) sb_q.push_back(d);
        mlevel = mlevel + (pa ? 1 : 0) - (ra ? 1 : 0);
        @(posedge aclk);
        #1;
        push = 1'b0; pop = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_pop_valid", 32'(pop_valid), 32'd0);
        chk("rst_pop_data", pop_data, 32'd0);
        chk("rst_flags", {28'd0, full, almost_empty, almost_full, overflow | underflow}, 32'b0100);
        @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk); #1;

        // Mid-operation reset at level 5 with a read in flight.
        for (int i = 0; i < 6; i++) step(1'b1, 32'h50 + i, 1'b0);
        step(1'b0, '0, 1'b1);
        chk("pre_rst_level", 32'(level), 32'd5);
        #2;
        areset = 1'b1;
        sb_q.delete();
        mlevel = 0;
        #1;
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_pop_valid", 32'(pop_valid), 32'd0);
        chk("midrst_pop_data", pop_data, 32'd0);
        chk("midrst_aempty", 32'(almost_empty), 32'd1);
        @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk); #1;

        // Fill 1..16 and overflow.
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, DW'(i), 1'b0);
            chk("fill_level", 32'(level), 32'(i));
            chk("fill_afull", 32'(almost_full), 32'(i >= 12));
            chk("fill_aempty", 32'(almost_empty), 32'(i <= 4));
            chk("fill_full", 32'(full), 32'(i == DEPTH));
        end
        step(1'b1, 32'hDEAD, 1'b0);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_level", 32'(level), 32'd16);
        step(1'b0, '0, 1'b0);
        chk("ovf_clear", 32'(overflow), 32'd0);

        // Push while full with a concurrent pop: push is still dropped.
        step(1'b1, 32'hBEEF, 1'b1);
        chk("full_pushpop_ovf", 32'(overflow), 32'd1);
        chk("full_pushpop_level", 32'(level), 32'd15);

        // Drain the remaining 2..16.
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        chk("drain_empty", 32'(empty), 32'd1);
        step(1'b0, '0, 1'b1);
        chk("udf_pulse", 32'(underflow), 32'd1);
        chk("udf_pop_valid", 32'(pop_valid), 32'd0);
        step(1'b0, '0, 1'b0);
        chk("udf_clear", 32'(underflow), 32'd0);

        // Concurrent push/pop at level 1 and at level 15.
        step(1'b1, 32'h100, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 32'h200 + i, 1'b1);
            chk("conc1_level", 32'(level), 32'd1);
            chk("conc1_ovudf", 32'(overflow | underflow), 32'd0);
        end
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b1, 32'h300 + i, 1'b0);
        chk("conc15_fill_level", 32'(level), 32'd15);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 32'h400 + i, 1'b1);
            chk("conc15_level", 32'(level), 32'd15);
            chk("conc15_ovudf", 32'(overflow | underflow), 32'd0);
            chk("conc15_full", 32'(full), 32'd0);
        end
        for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        chk("conc_drain_empty", 32'(empty), 32'd1);

        // Wrap the pointers past 2*DEPTH.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) begin
                step(1'b1, 32'h1000 * (r + 1) + i, 1'b0);
                chk("wrap_push_flags", {30'd0, full, empty}, 32'b00);
            end
            for (int i = 0; i < 10; i++) begin
                step(1'b0, '0, 1'b1);
                chk("wrap_pop_flags", {30'd0, full, empty}, {31'd0, i == 9});
            end
        end
        step(1'b0, '0, 1'b0);

`ifdef FIFO_FWFT_EN
        step(1'b1, 32'hA5, 1'b0);
        chk("fwft_data", pop_data, 32'hA5);
        chk("fwft_valid", 32'(pop_valid), 32'd1);
        step(1'b0, '0, 1'b1);
        chk("fwft_empty", 32'(empty), 32'd1);
`endif

        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
